control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq_pkg.sv | 65 ++++++
 rtl/control_seq_microcode_rom.sv | 70 +++++++
 rtl/control_seq.sv | 65 ++++++
 tb/tb_control_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/control_seq_pkg.sv
// Shared constants for the microcoded control sequencer: control-word bit map,
// opcodes, microstep encoding and the fixed fetch words.
package control_seq_pkg;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    localparam logic [15:0] M_HLT = 16'(1) << B_HLT;
    localparam logic [15:0] M_MI  = 16'(1) << B_MI;
    localparam logic [15:0] M_RI  = 16'(1) << B_RI;
    localparam logic [15:0] M_RO  = 16'(1) << B_RO;
    localparam logic [15:0] M_IO  = 16'(1) << B_IO;
    localparam logic [15:0] M_II  = 16'(1) << B_II;
    localparam logic [15:0] M_AI  = 16'(1) << B_AI;
    localparam logic [15:0] M_AO  = 16'(1) << B_AO;
    localparam logic [15:0] M_EO  = 16'(1) << B_EO;
    localparam logic [15:0] M_SU  = 16'(1) << B_SU;
    localparam logic [15:0] M_BI  = 16'(1) << B_BI;
    localparam logic [15:0] M_OI  = 16'(1) << B_OI;
    localparam logic [15:0] M_CE  = 16'(1) << B_CE;
    localparam logic [15:0] M_CO  = 16'(1) << B_CO;
    localparam logic [15:0] M_J   = 16'(1) << B_J;
    localparam logic [15:0] M_FI  = 16'(1) << B_FI;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int STEPS = 5;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [15:0] FETCH_T0  = M_CO | M_MI;
    localparam logic [15:0] FETCH_T1  = M_RO | M_II | M_CE;
    localparam logic [15:0] HALT_WORD = M_HLT;

endpackage

// File: rtl/control_seq_microcode_rom.sv
// Combinational microcode decode: control word and last-step flag for the
// current (microstep, opcode, flags). Unlisted opcodes decode as NOP.
module microcode_rom
    import control_seq_pkg::*;
(
    input  logic [2:0]  tstate,
    input  logic [3:0]  opcode,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl_word,
    output logic        last_step
);

    logic [2:0] last_idx;

    always_comb begin
        last_idx = T2;
        case (opcode)
            OP_ADD, OP_SUB: last_idx = T4;
            OP_LDA, OP_STA: last_idx = T3;
            default:        last_idx = T2;
        endcase
    end

    // Fetch steps never wrap; out-of-range step codes wrap to recover.
    always_comb begin
        case (tstate)
            T0, T1:  last_step = 1'b0;
            T2, T3:  last_step = (tstate >= last_idx);
            default: last_step = 1'b1;
        endcase
    end

    always_comb begin
        ctrl_word = '0;
        case (tstate)
            T0: ctrl_word = FETCH_T0;
            T1: ctrl_word = FETCH_T1;
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_word = M_IO | M_MI;
                    OP_LDI: ctrl_word = M_IO | M_AI;
                    OP_JMP: ctrl_word = M_IO | M_J;
                    OP_JC:  ctrl_word = cf ? (M_IO | M_J) : '0;
                    OP_JZ:  ctrl_word = zf ? (M_IO | M_J) : '0;
                    OP_OUT: ctrl_word = M_AO | M_OI;
                    OP_HLT: ctrl_word = M_HLT;
                    default: ctrl_word = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA:         ctrl_word = M_RO | M_AI;
                    OP_ADD, OP_SUB: ctrl_word = M_RO | M_BI;
                    OP_STA:         ctrl_word = M_AO | M_RI;
                    default:        ctrl_word = '0;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD:  ctrl_word = M_EO | M_AI | M_FI;
                    OP_SUB:  ctrl_word = M_EO | M_SU | M_AI | M_FI;
                    default: ctrl_word = '0;
                endcase
            end
            default: ctrl_word = '0;
        endcase
    end

endmodule

// File: rtl/control_seq.sv
// Microstep sequencer: step counter, sticky halt register and reset handling
// around the combinational microcode ROM.
module control_seq
    import control_seq_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl,
    output logic [2:0]  tstate,
    output logic        halted
);

    logic [15:0] rom_word;
    logic        last_step;
    logic [2:0]  tstate_next;
    logic        halted_next;

    microcode_rom u_rom (
        .tstate    (tstate),
        .opcode    (opcode),
        .cf        (cf),
        .zf        (zf),
        .ctrl_word (rom_word),
        .last_step (last_step)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            tstate <= T0;
            halted <= 1'b0;
        end else begin
            tstate <= tstate_next;
            halted <= halted_next;
        end
    end

    // HLT holds the counter at T2 instead of wrapping, then halted freezes it.
    always_comb begin
        tstate_next = tstate;
        halted_next = halted;
        if (!halted) begin
            if (tstate == T2 && opcode == OP_HLT) begin
                halted_next = 1'b1;
            end else if (last_step) begin
                tstate_next = T0;
            end else begin
                tstate_next = tstate + 3'd1;
            end
        end
    end

    always_comb begin
        if (!clr) begin
            ctrl = FETCH_T0;
        end else if (halted) begin
            ctrl = HALT_WORD;
        end else begin
            ctrl = rom_word;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: table-driven instruction model checked every cycle,
// plus directed literal expectations along the instruction walk.
module tb_control_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic [15:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;

    int n_total = 0;
    int n_pass  = 0;

    control_seq dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .cf     (cf),
        .zf     (zf),
        .ctrl   (ctrl),
        .tstate (tstate),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Instruction model: per-opcode length and execute words for steps 2..4.
    int          m_len [16];
    logic [15:0] m_word [16][5];
    int          m_step   = 0;
    logic        m_halted = 1'b0;
    logic        m_valid  = 1'b0;

    initial begin
        for (int o = 0; o < 16; o++) begin
            m_len[o] = 3;
            for (int s = 0; s < 5; s++) m_word[o][s] = 16'h0000;
        end
        m_len[1] = 4; m_word[1][2] = 16'h4800; m_word[1][3] = 16'h1200;
        m_len[2] = 5; m_word[2][2] = 16'h4800; m_word[2][3] = 16'h1020; m_word[2][4] = 16'h0281;
        m_len[3] = 5; m_word[3][2] = 16'h4800; m_word[3][3] = 16'h1020; m_word[3][4] = 16'h02C1;
        m_len[4] = 4; m_word[4][2] = 16'h4800; m_word[4][3] = 16'h2100;
        m_word[5][2]  = 16'h0A00;
        m_word[6][2]  = 16'h0802;
        m_word[7][2]  = 16'h0802;
        m_word[8][2]  = 16'h0802;
        m_word[14][2] = 16'h0110;
        m_word[15][2] = 16'h8000;
    end

    function automatic logic [15:0] model_ctrl();
        if (!clr)          return 16'h4004;
        if (m_halted)      return 16'h8000;
        if (m_step == 0)   return 16'h4004;
        if (m_step == 1)   return 16'h1408;
        if (m_step == 2 && opcode == 4'h7 && !cf) return 16'h0000;
        if (m_step == 2 && opcode == 4'h8 && !zf) return 16'h0000;
        return m_word[opcode][m_step];
    endfunction

    always @(posedge clk) begin
        if (!clr) begin
            m_step   <= 0;
            m_halted <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_halted) begin
            m_step <= m_step;
        end else if (m_step == 2 && opcode == 4'hF) begin
            m_halted <= 1'b1;
        end else begin
            m_step <= (m_step + 1 >= m_len[opcode]) ? 0 : m_step + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ctrl", 32'(ctrl), 32'(model_ctrl()));
            check("model_tstate", 32'(tstate), 32'(m_step));
            check("model_halted", 32'(halted), 32'(m_halted));
        end
    end

    // One clock: apply opcode, check the literal expectation mid-cycle.
    task automatic cyc(input logic [3:0] op, input int ets, input logic [15:0] ectrl);
        opcode = op;
        @(negedge clk);
        check("lit_tstate", 32'(tstate), 32'(ets));
        check("lit_ctrl", 32'(ctrl), 32'(ectrl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        clr = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_halted", 32'(halted), 32'd0);
        cyc(4'h0, 0, 16'h4004);
        clr = 1'b1;

        // NOP free-run
        for (int r = 0; r < 2; r++) begin
            cyc(4'h0, 0, 16'h4004); cyc(4'h0, 1, 16'h1408); cyc(4'h0, 2, 16'h0000);
        end
        // ADD, SUB
        cyc(4'h2, 0, 16'h4004); cyc(4'h2, 1, 16'h1408); cyc(4'h2, 2, 16'h4800);
        cyc(4'h2, 3, 16'h1020); cyc(4'h2, 4, 16'h0281);
        cyc(4'h3, 0, 16'h4004); cyc(4'h3, 1, 16'h1408); cyc(4'h3, 2, 16'h4800);
        cyc(4'h3, 3, 16'h1020); cyc(4'h3, 4, 16'h02C1);
        // LDA wraps after T3, STA
        cyc(4'h1, 0, 16'h4004); cyc(4'h1, 1, 16'h1408); cyc(4'h1, 2, 16'h4800);
        cyc(4'h1, 3, 16'h1200);
        cyc(4'h4, 0, 16'h4004); cyc(4'h4, 1, 16'h1408); cyc(4'h4, 2, 16'h4800);
        cyc(4'h4, 3, 16'h2100);
        // JC / JZ; flag toggles outside T2 must not matter
        cf = 1'b0; cyc(4'h7, 0, 16'h4004); cf = 1'b0; cyc(4'h7, 1, 16'h1408);
        cf = 1'b1; cyc(4'h7, 2, 16'h0802);
        cf = 1'b1; cyc(4'h7, 0, 16'h4004); cyc(4'h7, 1, 16'h1408);
        cf = 1'b0; cyc(4'h7, 2, 16'h0000);
        cyc(4'h8, 0, 16'h4004); cyc(4'h8, 1, 16'h1408);
        zf = 1'b1; cyc(4'h8, 2, 16'h0802);
        cyc(4'h8, 0, 16'h4004); cyc(4'h8, 1, 16'h1408);
        zf = 1'b0; cyc(4'h8, 2, 16'h0000);
        // LDI, JMP, OUT, undefined opcode
        cyc(4'h5, 0, 16'h4004); cyc(4'h5, 1, 16'h1408); cyc(4'h5, 2, 16'h0A00);
        cyc(4'h6, 0, 16'h4004); cyc(4'h6, 1, 16'h1408); cyc(4'h6, 2, 16'h0802);
        cyc(4'hE, 0, 16'h4004); cyc(4'hE, 1, 16'h1408); cyc(4'hE, 2, 16'h0110);
        cyc(4'hB, 0, 16'h4004); cyc(4'hB, 1, 16'h1408); cyc(4'hB, 2, 16'h0000);
        // HLT, then inputs ignored
        cyc(4'hF, 0, 16'h4004); cyc(4'hF, 1, 16'h1408); cyc(4'hF, 2, 16'h8000);
        for (int i = 0; i < 12; i++) begin
            cf = (i % 2 == 1);
            zf = (i % 3 == 0);
            cyc(4'(i), 2, 16'h8000);
        end
        @(negedge clk);
        check("lit_halted_set", 32'(halted), 32'd1);
        @(posedge clk);
        #1;
        // One-edge reset out of halt
        clr = 1'b0;
        cyc(4'h3, 2, 16'h4004);
        clr = 1'b1;
        @(negedge clk);
        check("lit_halted_clr", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        cyc(4'h0, 1, 16'h1408);
        cyc(4'h0, 2, 16'h0000);
        // Reset in the middle of ADD T3
        cyc(4'h2, 0, 16'h4004); cyc(4'h2, 1, 16'h1408); cyc(4'h2, 2, 16'h4800);
        clr = 1'b0;
        cyc(4'h2, 3, 16'h4004);
        clr = 1'b1;
        cyc(4'h2, 0, 16'h4004); cyc(4'h2, 1, 16'h1408); cyc(4'h2, 2, 16'h4800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
